// File: rtl/multiport_regfile.sv
// Multi-port register file: two prioritised write ports, two registered read
// ports, optional bypass and zero register, per-register busy scoreboard.
module multiport_regfile #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 5,
  parameter int REG_SIZE  = 32,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] Read_reg1,
  input  logic [ADDR_BITS-1:0] Read_reg2,
  output logic [DATA_BITS-1:0] Read_data1,
  output logic [DATA_BITS-1:0] Read_data2,
  output logic                 Read_busy1,
  output logic                 Read_busy2,
  input  logic                 Write_enable0,
  input  logic                 Write_enable1,
  input  logic [ADDR_BITS-1:0] Write_reg0,
  input  logic [ADDR_BITS-1:0] Write_reg1,
  input  logic [DATA_BITS-1:0] Write_data0,
  input  logic [DATA_BITS-1:0] Write_data1,
  input  logic                 Issue_enable,
  input  logic [ADDR_BITS-1:0] Issue_reg
);

  logic [DATA_BITS-1:0] regs_q [REG_SIZE];
  logic [DATA_BITS-1:0] regs_d [REG_SIZE];
  logic [REG_SIZE-1:0]  busy_q;
  logic [REG_SIZE-1:0]  busy_d;

  logic [ADDR_BITS-1:0] raddr   [2];
  logic [DATA_BITS-1:0] rdata_q [2];
  logic [DATA_BITS-1:0] rdata_d [2];
  logic                 rbusy_q [2];
  logic                 rbusy_d [2];

  function automatic logic rd_ok(input logic [ADDR_BITS-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = {1'b0, a} < (ADDR_BITS+1)'(REG_SIZE);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  // Port 1 is applied after port 0 so it wins; issue is applied last so
  // the newer producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < REG_SIZE; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (Write_enable0 && (Write_reg0 == ADDR_BITS'(i))) begin
          regs_d[i] = Write_data0;
          busy_d[i] = 1'b0;
        end
        if (Write_enable1 && (Write_reg1 == ADDR_BITS'(i))) begin
          regs_d[i] = Write_data1;
          busy_d[i] = 1'b0;
        end
        if (Issue_enable && (Issue_reg == ADDR_BITS'(i))) begin
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  assign raddr[0] = Read_reg1;
  assign raddr[1] = Read_reg2;

  // With bypass the next-state view already folds in this edge's updates.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_d[p] = '0;
      rbusy_d[p] = 1'b0;
      if (rd_ok(raddr[p])) begin
        if (BYPASS != 0) begin
          rdata_d[p] = regs_d[raddr[p]];
          rbusy_d[p] = busy_d[raddr[p]];
        end else begin
          rdata_d[p] = regs_q[raddr[p]];
          rbusy_d[p] = busy_q[raddr[p]];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      for (int p = 0; p < 2; p++) begin
        rdata_q[p] <= '0;
        rbusy_q[p] <= 1'b0;
      end
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      for (int p = 0; p < 2; p++) begin
        rdata_q[p] <= rdata_d[p];
        rbusy_q[p] <= rbusy_d[p];
      end
    end
  end

  assign Read_data1 = rdata_q[0];
  assign Read_data2 = rdata_q[1];
  assign Read_busy1 = rbusy_q[0];
  assign Read_busy2 = rbusy_q[1];

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: three configurations share one stimulus
// stream; expected read results are queued and checked by a monitor.
module tb_multiport_regfile;

  logic        CLK;
  logic        rst;
  logic [4:0]  Read_reg1, Read_reg2;
  logic        Write_enable0, Write_enable1;
  logic [4:0]  Write_reg0, Write_reg1;
  logic [31:0] Write_data0, Write_data1;
  logic        Issue_enable;
  logic [4:0]  Issue_reg;

  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  logic        rb1 [3];
  logic        rb2 [3];

  typedef struct {
    int          cyc;
    int          sel;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          errors;
  int          checks;
  logic [31:0] exp_mem [24];

  multiport_regfile #(.BYPASS(1)) dut_byp (
    .CLK(CLK), .rst(rst),
    .Read_reg1(Read_reg1), .Read_reg2(Read_reg2),
    .Read_data1(rd1[0]), .Read_data2(rd2[0]),
    .Read_busy1(rb1[0]), .Read_busy2(rb2[0]),
    .Write_enable0(Write_enable0), .Write_enable1(Write_enable1),
    .Write_reg0(Write_reg0), .Write_reg1(Write_reg1),
    .Write_data0(Write_data0), .Write_data1(Write_data1),
    .Issue_enable(Issue_enable), .Issue_reg(Issue_reg)
  );

  multiport_regfile #(.BYPASS(0)) dut_nob (
    .CLK(CLK), .rst(rst),
    .Read_reg1(Read_reg1), .Read_reg2(Read_reg2),
    .Read_data1(rd1[1]), .Read_data2(rd2[1]),
    .Read_busy1(rb1[1]), .Read_busy2(rb2[1]),
    .Write_enable0(Write_enable0), .Write_enable1(Write_enable1),
    .Write_reg0(Write_reg0), .Write_reg1(Write_reg1),
    .Write_data0(Write_data0), .Write_data1(Write_data1),
    .Issue_enable(Issue_enable), .Issue_reg(Issue_reg)
  );

  multiport_regfile #(.REG_SIZE(24)) dut_small (
    .CLK(CLK), .rst(rst),
    .Read_reg1(Read_reg1), .Read_reg2(Read_reg2),
    .Read_data1(rd1[2]), .Read_data2(rd2[2]),
    .Read_busy1(rb1[2]), .Read_busy2(rb2[2]),
    .Write_enable0(Write_enable0), .Write_enable1(Write_enable1),
    .Write_reg0(Write_reg0), .Write_reg1(Write_reg1),
    .Write_data0(Write_data0), .Write_data1(Write_data1),
    .Issue_enable(Issue_enable), .Issue_reg(Issue_reg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic expect_rd(input int sel, input int port,
                           input logic [31:0] data, input logic busy,
                           input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.port = port;
    e.data = data;
    e.busy = busy;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge CLK);
    Write_enable0 = 1'b0;
    Write_enable1 = 1'b0;
    Issue_enable  = 1'b0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    Write_enable0 = 1'b1;
    Write_reg0    = a;
    Write_data0   = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    Write_enable1 = 1'b1;
    Write_reg1    = a;
    Write_data1   = d;
  endtask

  task automatic issue(input logic [4:0] a);
    Issue_enable = 1'b1;
    Issue_reg    = a;
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires the
  // expectations that were queued for it.
  initial begin
    exp_t        e;
    logic [31:0] ad;
    logic        ab;
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: missed cycle %0d, now %0d", e.name, e.cyc, cyc);
        end else begin
          ad = (e.port == 1) ? rd1[e.sel] : rd2[e.sel];
          ab = (e.port == 1) ? rb1[e.sel] : rb2[e.sel];
          if (ad !== e.data || ab !== e.busy) begin
            errors++;
            $display("FAIL %s: dut%0d port%0d got data=%h busy=%b want data=%h busy=%b",
                     e.name, e.sel, e.port, ad, ab, e.data, e.busy);
          end
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    Read_reg1 = '0;
    Read_reg2 = '0;
    Write_enable0 = 1'b0;
    Write_enable1 = 1'b0;
    Write_reg0 = '0;
    Write_reg1 = '0;
    Write_data0 = '0;
    Write_data1 = '0;
    Issue_enable = 1'b0;
    Issue_reg = '0;

    // held in reset
    tick();
    Read_reg1 = 5'd1;
    Read_reg2 = 5'd1;
    for (int s = 0; s < 3; s++) expect_rd(s, 1, 32'h0, 1'b0, "rst_hold");

    // r5 write then asynchronous reset mid-cycle
    tick();
    rst = 1'b0;
    wr0(5'd5, 32'hDEADBEEF);
    Read_reg1 = 5'd5;
    expect_rd(0, 1, 32'hDEADBEEF, 1'b0, "r5_byp");
    expect_rd(1, 1, 32'h0, 1'b0, "r5_nob_old");
    tick();
    Read_reg1 = 5'd5;
    Read_reg2 = 5'd5;
    expect_rd(1, 1, 32'hDEADBEEF, 1'b0, "r5_nob_new");
    expect_rd(0, 2, 32'hDEADBEEF, 1'b0, "r5_byp_p2");
    @(posedge CLK);
    #3;
    rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (rd1[s] !== 32'h0 || rd2[s] !== 32'h0) begin
        errors++;
        $display("FAIL async_rst: dut%0d got %h/%h want 0", s, rd1[s], rd2[s]);
      end
    end
    tick();
    rst = 1'b0;
    Read_reg1 = 5'd5;
    Read_reg2 = 5'd5;
    expect_rd(0, 1, 32'h0, 1'b0, "r5_after_rst");
    expect_rd(1, 2, 32'h0, 1'b0, "r5_after_rst_nob");

    // zero register
    tick();
    wr0(5'd0, 32'h12345678);
    issue(5'd0);
    Read_reg1 = 5'd0;
    Read_reg2 = 5'd0;
    expect_rd(0, 1, 32'h0, 1'b0, "r0_byp_p1");
    expect_rd(0, 2, 32'h0, 1'b0, "r0_byp_p2");
    tick();
    expect_rd(0, 1, 32'h0, 1'b0, "r0_p1");
    expect_rd(1, 2, 32'h0, 1'b0, "r0_nob_p2");

    // dual-write collision
    tick();
    wr0(5'd7, 32'h11111111);
    wr1(5'd7, 32'h22222222);
    Read_reg1 = 5'd7;
    Read_reg2 = 5'd7;
    expect_rd(0, 1, 32'h22222222, 1'b0, "r7_byp");
    expect_rd(1, 1, 32'h0, 1'b0, "r7_nob_old");
    tick();
    expect_rd(0, 1, 32'h22222222, 1'b0, "r7_p1");
    expect_rd(1, 1, 32'h22222222, 1'b0, "r7_nob_p1");
    expect_rd(1, 2, 32'h22222222, 1'b0, "r7_nob_p2");

    // bypass vs no bypass
    tick();
    wr0(5'd3, 32'hA5A5A5A5);
    Read_reg1 = 5'd3;
    expect_rd(0, 1, 32'hA5A5A5A5, 1'b0, "r3_byp");
    expect_rd(1, 1, 32'h0, 1'b0, "r3_nob_old");
    tick();
    expect_rd(1, 1, 32'hA5A5A5A5, 1'b0, "r3_nob_new");

    // busy scoreboard on r9
    tick();
    issue(5'd9);
    Read_reg2 = 5'd9;
    expect_rd(0, 2, 32'h0, 1'b1, "r9_iss_byp");
    expect_rd(1, 2, 32'h0, 1'b0, "r9_iss_nob");
    tick();
    expect_rd(0, 2, 32'h0, 1'b1, "r9_busy");
    expect_rd(1, 2, 32'h0, 1'b1, "r9_busy_nob");
    tick();
    wr1(5'd9, 32'h000000FF);
    expect_rd(0, 2, 32'h000000FF, 1'b0, "r9_wr_byp");
    expect_rd(1, 2, 32'h0, 1'b1, "r9_wr_nob");
    tick();
    expect_rd(0, 2, 32'h000000FF, 1'b0, "r9_done");
    expect_rd(1, 2, 32'h000000FF, 1'b0, "r9_done_nob");
    tick();
    issue(5'd9);
    wr0(5'd9, 32'h00001234);
    expect_rd(0, 2, 32'h00001234, 1'b1, "r9_isswr_byp");
    expect_rd(1, 2, 32'h000000FF, 1'b0, "r9_isswr_nob");
    tick();
    expect_rd(0, 2, 32'h00001234, 1'b1, "r9_isswr");
    expect_rd(1, 2, 32'h00001234, 1'b1, "r9_isswr_nob2");

    // out of range on the 24-entry instance
    tick();
    wr0(5'd30, 32'hFFFFFFFF);
    Read_reg1 = 5'd30;
    expect_rd(2, 1, 32'h0, 1'b0, "r30_oor_byp");
    expect_rd(0, 1, 32'hFFFFFFFF, 1'b0, "r30_inrange");
    tick();
    expect_rd(2, 1, 32'h0, 1'b0, "r30_oor");

    for (int i = 0; i < 24; i++) exp_mem[i] = 32'h0;
    exp_mem[3] = 32'hA5A5A5A5;
    exp_mem[7] = 32'h22222222;
    exp_mem[9] = 32'h00001234;
    for (int i = 0; i < 24; i++) begin
      tick();
      Read_reg1 = 5'(i);
      Read_reg2 = 5'(23 - i);
      expect_rd(2, 1, exp_mem[i], (i == 9), "small_p1");
      expect_rd(2, 2, exp_mem[23 - i], ((23 - i) == 9), "small_p2");
    end

    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

- Parametrised successor to the team's single-write register file.
- Adds:
  - configurable data width and depth;
  - two write ports with fixed priority;
  - optional write-to-read bypass;
  - optional hardwired zero register;
  - a per-register busy scoreboard for in-flight producers.
- Sits between decode (read/issue) and writeback (write) in the core pipeline. All reads are registered with one-cycle latency.

## Interface

Parameters:
- DATA_BITS, 32, register width
- ADDR_BITS, 5, register index width
- REG_SIZE, 32, number of registers (must be ≤ 2**ADDR_BITS)
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs; 0 = read returns pre-write contents
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- Read_reg1, Read_reg2  in  ADDR_BITS  read addresses
- Read_data1, Read_data2  out  DATA_BITS  registered read data
- Read_busy1, Read_busy2  out  1  registered busy flag of the addressed register
- Write_enable0, Write_enable1  in  1  write strobes
- Write_reg0, Write_reg1  in  ADDR_BITS  write addresses
- Write_data0, Write_data1  in  DATA_BITS  write data
- Issue_enable  in  1  mark a register as having a pending producer
- Issue_reg  in  ADDR_BITS  register to mark busy

## Operation

- Reset (async assert, any time, including mid-operation):
  - every register = 0; every busy bit = 0;
  - Read_data1/2 = 0; Read_busy1/2 = 0;
  - state held while rst = 1.
- Writes:
  - An enabled port writes its data on the edge and clears busy[Write_regN].
  - Both ports enabled, same address: port 1 wins (data). The busy bit is cleared once.
  - Writes to addresses ≥ REG_SIZE are ignored.
  - ZERO_REG = 1: writes to address 0 are ignored.
- Issue:
  - Issue_enable sets busy[Issue_reg] on the edge.
  - Issue and write to the same register in the same cycle: busy ends set. Issue represents the newer producer; the write data is still stored.
  - Issue to register 0 with ZERO_REG = 1 is ignored.
- Reads:
  - Each read port registers data and busy for its address every cycle. No read enable.
  - BYPASS = 1 and an enabled write hits the read address this cycle: Read_dataN = forwarded write data (port 1 over port 0), and Read_busyN = 0 unless Issue hits the same address (then 1).
  - BYPASS = 0: Read_dataN / Read_busyN = stored contents and busy before this edge's updates.
  - Address ≥ REG_SIZE: Read_dataN = 0, Read_busyN = 0.
  - ZERO_REG = 1, address 0: Read_dataN = 0, Read_busyN = 0 always.
- Both read ports may address the same register; both return identical values.

## Timing

- Read latency: 1 cycle. Address at edge k → data/busy valid after edge k, stable until edge k+1.
- Write latency:
  - stored at edge k;
  - BYPASS = 1: visible on the read outputs at edge k;
  - BYPASS = 0: visible at edge k+1.
- Busy set latency:
  - issue at edge k → busy stored at edge k;
  - a read at edge k reports 1 only if BYPASS = 1;
  - a read at edge k+1 always reports 1.
- No combinational path from any input to any output.
- Reset deassertion: first update on the next rising CLK edge with rst = 0.

## Test plan

- Reset:
  - Write 0xDEADBEEF to r5, assert rst mid-cycle.
  - Read_data1/2 go to 0 immediately without a CLK edge.
  - After release, reading r5 returns 0 and Read_busy = 0.
- Zero register (ZERO_REG = 1):
  - Write 0x12345678 to r0 and issue r0.
  - Reading r0 on both ports returns 0x00000000 with busy 0.
- Dual-write collision:
  - Same cycle: port 0 writes r7 = 0x11111111, port 1 writes r7 = 0x22222222.
  - Next-cycle read of r7 returns 0x22222222.
- Bypass:
  - BYPASS = 1: write r3 = 0xA5A5A5A5 while Read_reg1 = 3. Read_data1 = 0xA5A5A5A5 right after that edge.
  - BYPASS = 0: the same stimulus returns the old value (0), then 0xA5A5A5A5 one cycle later.
- Scoreboard:
  - Issue r9 → Read_busy2 on r9 = 1.
  - Write r9 = 0x0000_00FF → busy 0 and data 0xFF.
  - Issue r9 and write r9 in the same cycle → busy stays 1 and data is updated.
- Out-of-range (REG_SIZE = 24, ADDR_BITS = 5):
  - Write r30 = 0xFFFFFFFF.
  - Reading r30 returns 0 and busy 0.
  - Registers r0–r23 are unchanged.
